// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

    // Scan FSM: BLANK keeps all digits dark, DRIVE enables the current digit.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Segment pattern with every segment off (active-high encoding).
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Converts an active-high segment pattern to the panel's drive polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-word load handshake between a producer and the scan controller.
//
// Handshake: a word transfers on every rising clk edge where load_valid and
// load_ready are both 1. The producer holds load_data/load_dp stable while
// load_valid is high and may only change them after a transfer. load_ready
// does not depend combinationally on load_valid.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [NUM_DIGITS-1:0]   load_dp;

    modport master (output load_valid, output load_data, output load_dp, input load_ready);
    modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/seg_refresh_timer.sv
// Slot timer for the display scan: slot counter, digit index, BLANK/DRIVE FSM.
module seg_refresh_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic                          drive,
    output logic                          frame_end,
    output scan_state_t                   state
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx_nxt;
    scan_state_t   state_nxt;

    // State, slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: disable parks the scan at digit 0 in BLANK; the last
    // cycle of a slot advances the digit and restarts the blanking interval.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (!enable) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt_nxt = cnt + CW'(1);
            if (state == BLANK && cnt == BLANK_LAST) begin
                state_nxt = DRIVE;
            end
        end
    end

    assign drive     = (state == DRIVE);
    assign frame_end = enable && (state == DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display sharing
// one external hex decoder. New words are double-buffered and committed only
// at frame boundaries so a frame never shows a mix of two words.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  lz_en,
    seg_scan_ctrl_if.slave        load,
    output logic [3:0]            dec_nibble,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output scan_state_t           scan_state
);
    localparam int IW         = $clog2(NUM_DIGITS);
    localparam bit ACTIVE_LOW = (SEG_ACTIVE_LOW != 0);

    logic [NUM_DIGITS-1:0][3:0] display, pending;
    logic [NUM_DIGITS-1:0]      display_dp, pending_dp;
    logic                       pending_flag, pending_flag_nxt;
    logic                       ready_q;
    logic                       xfer, commit;
    logic [IW-1:0]              idx;
    logic                       drive, frame_end;
    logic [NUM_DIGITS-1:0]      suppress;
    logic                       blank_above;

    seg_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .idx      (idx),
        .drive    (drive),
        .frame_end(frame_end),
        .state    (scan_state)
    );

    // A transfer can only happen with nothing pending, so xfer and commit
    // never coincide; a word arriving on the boundary waits a full frame.
    assign xfer             = load.load_valid && ready_q;
    assign commit           = pending_flag && (frame_end || !enable);
    assign pending_flag_nxt = commit ? 1'b0 : (xfer ? 1'b1 : pending_flag);
    assign load.load_ready  = ready_q;

    // Pending/display word registers and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pending_dp   <= '0;
            display      <= '0;
            display_dp   <= '0;
            pending_flag <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            if (xfer) begin
                pending    <= load.load_data;
                pending_dp <= load.load_dp;
            end
            if (commit) begin
                display    <= pending;
                display_dp <= pending_dp;
            end
            pending_flag <= pending_flag_nxt;
            ready_q      <= !pending_flag_nxt;
        end
    end

    // Leading-zero suppression: walk down from the MSD while digits are zero
    // with no decimal point; digit 0 is never suppressed.
    always_comb begin
        suppress    = '0;
        blank_above = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            blank_above = blank_above && (display[i] == 4'h0) && !display_dp[i];
            suppress[i] = blank_above;
        end
    end

    // Digit enables: only the current digit, only in DRIVE, only if lit.
    always_comb begin
        an_n = '1;
        if (drive && !suppress[idx]) begin
            an_n[idx] = 1'b0;
        end
    end

    assign dec_nibble = display[idx];

    // Segment and decimal-point output registers, one decode cycle behind idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= seg_polarity(SEG_OFF, ACTIVE_LOW);
            dp_out  <= ACTIVE_LOW;
        end else begin
            seg_out <= seg_polarity(dec_seg, ACTIVE_LOW);
            dp_out  <= display_dp[idx] ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an active-high and an active-low instance share
// the same stimulus; each feeds its own behavioural hex decoder.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n, enable, lz_en, load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;

    logic [3:0]  nib_a, nib_b, an_a, an_b;
    logic [6:0]  dec_a, dec_b, seg_a, seg_b;
    logic        dp_a, dp_b;
    scan_state_t st_a, st_b;

    int vectors = 0;
    int miscompares = 0;

    // Cycle expectation: [16]=check seg/dp, [15:12]=an_n, [11:8]=nibble, [7:1]=seg, [0]=dp
    logic [16:0] exp_q[$];
    // Accepted words awaiting display: {dp, data}
    logic [19:0] word_q[$];
    logic [15:0] cur_w;
    logic [3:0]  cur_dp;

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    assign dec_a = hex7(nib_a);
    assign dec_b = hex7(nib_b);

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) load_a ();
    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) load_b ();
    assign load_a.load_valid = load_valid;
    assign load_a.load_data  = load_data;
    assign load_a.load_dp    = load_dp;
    assign load_b.load_valid = load_valid;
    assign load_b.load_data  = load_data;
    assign load_b.load_dp    = load_dp;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en), .load(load_a.slave),
        .dec_nibble(nib_a), .dec_seg(dec_a), .seg_out(seg_a), .dp_out(dp_a), .an_n(an_a),
        .scan_state(st_a)
    );

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en), .load(load_b.slave),
        .dec_nibble(nib_b), .dec_seg(dec_b), .seg_out(seg_b), .dp_out(dp_b), .an_n(an_b),
        .scan_state(st_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks n cycles of a frame showing word w, starting at frame position first.
    task automatic check_cycles(input logic [15:0] w, input logic [3:0] dp, input int first, input int n);
        logic [16:0] e;
        logic [3:0]  an_e, nib_e;
        logic        sup;
        int          p, d, c;
        for (int k = 0; k < n; k++) begin
            p = (first + k) % FRAME;
            d = p / RD;
            c = p % RD;
            nib_e = w[4*d +: 4];
            sup = 1'b0;
            if (lz_en && d > 0) begin
                sup = 1'b1;
                for (int j = d; j < ND; j++) begin
                    if (w[4*j +: 4] != 4'h0 || dp[j]) sup = 1'b0;
                end
            end
            an_e = 4'hF;
            if (c >= BC && !sup) an_e[d] = 1'b0;
            exp_q.push_back({(c != 0), an_e, nib_e, hex7(nib_e), dp[d]});
        end
        for (int k = 0; k < n; k++) begin
            p = (first + k) % FRAME;
            e = exp_q.pop_front();
            vectors++;
            if (an_a !== e[15:12]) begin
                miscompares++;
                $display("FAIL an_n pos %0d: got %b want %b", p, an_a, e[15:12]);
            end
            vectors++;
            if (an_b !== e[15:12]) begin
                miscompares++;
                $display("FAIL an_n_al pos %0d: got %b want %b", p, an_b, e[15:12]);
            end
            vectors++;
            if (nib_a !== e[11:8]) begin
                miscompares++;
                $display("FAIL dec_nibble pos %0d: got %h want %h", p, nib_a, e[11:8]);
            end
            if (e[16]) begin
                vectors++;
                if (seg_a !== e[7:1] || dp_a !== e[0]) begin
                    miscompares++;
                    $display("FAIL seg pos %0d: got %b/%b want %b/%b", p, seg_a, dp_a, e[7:1], e[0]);
                end
                vectors++;
                if (seg_b !== ~e[7:1] || dp_b !== ~e[0]) begin
                    miscompares++;
                    $display("FAIL seg_al pos %0d: got %b/%b want %b/%b", p, seg_b, dp_b, ~e[7:1], ~e[0]);
                end
            end
            step();
        end
    endtask

    task automatic expect_ready(input string tag, input logic want);
        vectors++;
        if (load_a.load_ready !== want || load_b.load_ready !== want) begin
            miscompares++;
            $display("FAIL ready %s: got %b/%b want %b", tag, load_a.load_ready, load_b.load_ready, want);
        end
    endtask

    // Offers a word for one cycle at frame position pos, while checking that cycle.
    task automatic drive_word(input logic [15:0] w, input logic [3:0] dp, input int pos);
        expect_ready("offer", 1'b1);
        load_valid = 1'b1;
        load_data  = w;
        load_dp    = dp;
        word_q.push_back({dp, w});
        check_cycles(cur_w, cur_dp, pos, 1);
        load_valid = 1'b0;
        load_data  = $urandom_range(0, 65535);
        load_dp    = 4'($urandom_range(0, 15));
    endtask

    task automatic take_next_word();
        vectors++;
        if (word_q.size() == 0) begin
            miscompares++;
            $display("FAIL word_q: got empty want one word");
        end else begin
            {cur_dp, cur_w} = word_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; lz_en = 1'b0; load_valid = 1'b0;
        load_data = '0; load_dp = '0;
        cur_w = '0; cur_dp = '0;
        step(); step();
        vectors++;
        if (an_a !== 4'hF || an_b !== 4'hF || seg_a !== 7'h00 || seg_b !== 7'h7F ||
            dp_a !== 1'b0 || dp_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset outputs: got %b %b %b %b %b %b want 1111 1111 0 7f 0 1",
                     an_a, an_b, seg_a, seg_b, dp_a, dp_b);
        end
        vectors++;
        if (nib_a !== 4'h0 || st_a !== BLANK || st_b !== BLANK) begin
            miscompares++;
            $display("FAIL reset state: got nib %h st %0d want nib 0 st BLANK", nib_a, st_a);
        end
        expect_ready("reset", 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        drive_word(16'h1234, 4'b0000, 0);
        expect_ready("pending", 1'b0);
        check_cycles(cur_w, cur_dp, 1, FRAME - 1);
        expect_ready("after commit", 1'b1);
        take_next_word();
        check_cycles(cur_w, cur_dp, 0, FRAME);
    endtask

    task automatic test_lz();
        lz_en = 1'b1;
        drive_word(16'h0005, 4'b0000, 0);
        check_cycles(cur_w, cur_dp, 1, FRAME - 1);
        take_next_word();
        drive_word(16'h0005, 4'b0100, 0);
        check_cycles(cur_w, cur_dp, 1, FRAME - 1);
        take_next_word();
        check_cycles(cur_w, cur_dp, 0, FRAME);
        lz_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bw[3];
        logic [3:0]  bd[3];
        bw[0] = 16'hABCD; bd[0] = 4'b0001;
        bw[1] = 16'h5678; bd[1] = 4'b0010;
        bw[2] = 16'h9E0F; bd[2] = 4'b1000;
        fork
            begin
                int stall;
                for (int w = 0; w < 3; w++) begin
                    stall = 0;
                    load_valid = 1'b1;
                    load_data  = bw[w];
                    load_dp    = bd[w];
                    while (load_a.load_ready !== 1'b1 && stall < 100) begin
                        step();
                        stall++;
                    end
                    if (w > 0) begin
                        vectors++;
                        if (stall != FRAME - 1) begin
                            miscompares++;
                            $display("FAIL b2b stall word %0d: got %0d want %0d", w, stall, FRAME - 1);
                        end
                    end
                    word_q.push_back({bd[w], bw[w]});
                    step();
                end
                load_valid = 1'b0;
            end
            begin
                check_cycles(cur_w, cur_dp, 0, FRAME);
                for (int f = 0; f < 3; f++) begin
                    take_next_word();
                    check_cycles(cur_w, cur_dp, 0, FRAME);
                end
            end
        join
        vectors++;
        if (word_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b leftover: got %0d words want 0", word_q.size());
        end
        expect_ready("b2b idle", 1'b1);
    endtask

    task automatic test_boundary();
        check_cycles(cur_w, cur_dp, 0, FRAME - 1);
        drive_word(16'h4321, 4'b0000, FRAME - 1);
        expect_ready("boundary held", 1'b0);
        check_cycles(cur_w, cur_dp, 0, FRAME);
        expect_ready("boundary commit", 1'b1);
        take_next_word();
    endtask

    task automatic test_enable();
        check_cycles(cur_w, cur_dp, 0, 19);
        drive_word(16'h0F0F, 4'b1000, 19);
        expect_ready("en pending", 1'b0);
        vectors++;
        if (an_a !== 4'b1011) begin
            miscompares++;
            $display("FAIL en digit2: got %b want 1011", an_a);
        end
        enable = 1'b0;
        step();
        expect_ready("en off", 1'b1);
        take_next_word();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (an_a !== 4'hF || an_b !== 4'hF || nib_a !== cur_w[3:0] || st_a !== BLANK) begin
                miscompares++;
                $display("FAIL en off cyc %0d: got %b %h %0d want 1111 %h 0", k, an_a, nib_a, st_a, cur_w[3:0]);
            end
            if (k < 3) step();
        end
        enable = 1'b1;
        check_cycles(cur_w, cur_dp, 0, FRAME);
    endtask

    task automatic test_async_reset();
        check_cycles(cur_w, cur_dp, 0, 10);
        drive_word(16'h7777, 4'b0000, 10);
        expect_ready("pre reset", 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (an_a !== 4'hF || an_b !== 4'hF || seg_a !== 7'h00 || seg_b !== 7'h7F ||
            dp_a !== 1'b0 || dp_b !== 1'b1 || nib_a !== 4'h0) begin
            miscompares++;
            $display("FAIL async reset: got %b %b %b %b %b %b %h", an_a, an_b, seg_a, seg_b, dp_a, dp_b, nib_a);
        end
        expect_ready("async reset", 1'b1);
        step();
        rst_n = 1'b1;
        word_q.delete();
        cur_w = '0;
        cur_dp = '0;
        check_cycles(cur_w, cur_dp, 0, 2 * FRAME);
        expect_ready("after reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_back_to_back();
        test_boundary();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit 7-segment display.
- Shares one hex-to-segment decoder across all digits, which saves N-1 decoder instances.
- Each cycle the block presents one nibble to the external decoder, registers the returned segment pattern, and drives active-low digit enables in rotation.
- A load handshake supplies new display words; they are committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit NUM_DIGITS-1 is the most significant.
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digits off, for ghost suppression (>= 1).
- SEG_ACTIVE_LOW, 0, 1 = invert seg_out and dp_out for common-anode panels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; 0 = display dark
- lz_en  in  1  leading-zero suppression enable
- load_valid  in  1  new display word offered
- load_ready  out  1  controller can accept a word
- load_data  in  4*NUM_DIGITS  nibble i at bits [4i+3:4i]
- load_dp  in  NUM_DIGITS  decimal point per digit
- dec_nibble  out  4  nibble for the current digit, to the shared decoder
- dec_seg  in  7  decoder result; active-high, bit6=g .. bit0=a, combinational from dec_nibble
- seg_out  out  7  registered segment drive
- dp_out  out  1  registered decimal point drive
- an_n  out  NUM_DIGITS  active-low digit enables; at most one low

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - an_n all 1; seg_out and dp_out at the off level (0, or all 1 if SEG_ACTIVE_LOW).
  - load_ready=1; display and pending registers 0; pending_flag=0.
  - digit index 0; slot counter 0; state BLANK.
- Handshake:
  - A word transfers on a cycle where load_valid && load_ready. It goes into the pending register and sets pending_flag.
  - load_ready = !pending_flag, driven from a register.
  - load_data and load_dp are ignored when no transfer occurs.
- FSM, two states; the slot counter runs 0..REFRESH_DIV-1:
  - BLANK: an_n all 1. Move to DRIVE when counter == BLANK_CYCLES-1.
  - DRIVE: an_n[idx] low, unless the digit is suppressed. At counter == REFRESH_DIV-1: counter returns to 0, idx = (idx+1) mod NUM_DIGITS, state returns to BLANK.
- Datapath:
  - dec_nibble = display[idx], combinational from registers.
  - seg_out and dp_out are registered from dec_seg and display_dp[idx] every cycle.
  - Because BLANK_CYCLES >= 1, seg_out is valid before the digit enable asserts (1-cycle decode latency).
- Frame boundary: the last DRIVE cycle of idx = NUM_DIGITS-1.
  - If pending_flag is set, pending is copied to display and pending_flag clears; load_ready reads 1 on the following cycle.
  - A transfer on the boundary cycle with no word pending is held for the next boundary, not committed in the same cycle.
- Leading-zero suppression, when lz_en=1:
  - Digit i > 0 is suppressed if display[j] == 0 for all j >= i.
  - A suppressed digit keeps an_n high for its whole slot, but its timing is still consumed.
  - Digit 0 is never suppressed.
  - A set dp bit on digit i cancels suppression for digit i and every digit below it.
- enable=0:
  - From the next cycle: an_n all 1, state BLANK, idx 0, counter 0, all held there.
  - Any pending word commits immediately. load_ready stays active.
  - When enable rises, the scan restarts at digit 0 in BLANK.
- Reset mid-scan: all outputs go to their reset values immediately; any pending word is lost.

Decomposition:
- Package seg_pkg holds:
  - the scan_state_t enum (BLANK, DRIVE);
  - constant SEG_OFF = 7'b0000000;
  - helper function seg_polarity(seg, active_low).
- Sub-module seg_refresh_timer holds the slot counter, the digit index and the BLANK/DRIVE FSM.
  - Outputs: idx, drive, frame_end.
  - The top level keeps the handshake, suppression logic and output registers.
- The hex-to-segment decoder stays external, instanced once beside this block.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then load 16'h1234:
  - Before the first frame boundary, dec_nibble=0 and an_n toggles.
  - After the commit, an_n follows 1111,1111,1110×6, then 1111×2,1101×6, and so on.
  - dec_nibble=4,3,2,1 per slot; seg_out=7'b1100110 while digit 0 is enabled.
- Load 16'h0005 with lz_en=1: only an_n[0] ever goes low. With load_dp=4'b0100 instead, digits 0..2 light and digit 3 stays dark.
- Back-to-back loads with load_valid held high:
  - The second word stalls with load_ready=0 until the cycle after the frame boundary.
  - Exactly one word commits per frame; no word is lost or duplicated.
- Transfer on the exact frame-boundary cycle: the word is not displayed during that frame, and commits at the next boundary 32 cycles later.
- Deassert enable mid-DRIVE on digit 2:
  - Next cycle an_n=1111, and a pending word commits.
  - Re-enable: BLANK for 2 cycles, then an_n=1110.
- Assert rst_n=0 asynchronously mid-slot: an_n=1111, seg_out=0 and load_ready=1 take effect without waiting for a clock edge. SEG_ACTIVE_LOW=1 run: seg_out is the bitwise complement in every case above.
